arbiter4x1_rr: RTL and testbench
================================

# arbiter4x1_rr

Round-robin burst arbiter that drains four upstream FIFOs (one per virtual channel) into a single shared downstream FIFO. It is the scheduling counterpart to the 1x2 classifier demux. The demux splits traffic into per-class FIFOs; this block merges per-class FIFOs back onto one link, honours downstream almost-full backpressure, and keeps one source from monopolising the link through a bounded burst length.

## Interface
- DATA_SIZE, 10, width of one word.
- BURST, 2, maximum consecutive grants to one source before rotation; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- fifo_empty  input  4  per-source empty flag; bit i high = FIFO i has no word.
- fifo_data0..fifo_data3  input  DATA_SIZE each  show-ahead head word of FIFO i; valid whenever fifo_empty[i]=0.
- out_almostfull  input  1  downstream FIFO cannot accept a word next cycle.
- pop  output  4  combinational, one-hot or zero; pops FIFO i at this rising edge.
- push_out  output  1  registered; pushes data_out into the downstream FIFO this cycle.
- data_out  output  DATA_SIZE  registered word being pushed.
- grant_id  output  2  registered index of the source that supplied data_out.

## Operation
- Internal state:
  - state ∈ {ARB, BURST}
  - cur[1:0]: current source
  - rr_ptr[1:0]: next-priority source
  - cnt[3:0]: grants in current burst
- Every pop depends on out_almostfull=0. When it is 1: pop=0, no state, pointer or count changes.
- ARB:
  - Scan sources in the order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4). The first i with fifo_empty[i]=0 wins.
  - If no source is non-empty: pop=0, stay in ARB.
  - On a winner: pop[i]=1, cur<=i, cnt<=1.
  - If BURST=1: rr_ptr<=i+1, stay in ARB. Otherwise go to BURST.
- BURST:
  - If fifo_empty[cur]=0: pop[cur]=1, cnt<=cnt+1. When cnt+1==BURST: rr_ptr<=cur+1, state<=ARB.
  - If fifo_empty[cur]=1: burst ends early. In the same cycle, perform the ARB scan starting from cur+1, with the ARB update rules above. No idle cycle is inserted.
- Datapath:
  - push_out<=|pop.
  - When |pop: data_out<=fifo_data[sel], grant_id<=sel.
  - Otherwise data_out and grant_id hold their last value.
- Pointer wrap is natural 2-bit modulo arithmetic (3+1 → 0).
- pop is never asserted for a source whose fifo_empty bit is 1. At most one pop bit is high.

## Timing
- Reset values, held while reset=1 regardless of clk:
  - pop=0, push_out=0, data_out=0, grant_id=0.
  - state=ARB, cur=0, rr_ptr=0, cnt=0.
- Reset asserted mid-burst aborts the burst. After reset release, arbitration restarts at source 0 on the first rising edge.
- Latency: a pop in cycle N gives push_out=1 with the matching data_out/grant_id in cycle N+1.
- Throughput: one word per cycle while any source is non-empty and out_almostfull=0, including across burst boundaries and early burst termination.
- out_almostfull is sampled combinationally in the cycle of the pop decision. The downstream FIFO must assert it with at least one word of slack, because one push may already be in flight.
- Simultaneous events:
  - Burst completion and a new request on the same source: rotation still happens, and other non-empty sources get priority first.
  - out_almostfull rising in the last burst cycle: the final grant is deferred and cnt is held.

## Test plan
1. Reset: run traffic, then assert reset for 15 ns between edges → pop, push_out, data_out and grant_id are 0 immediately. After release, the first grant goes to source 0.
2. Single source (BURST=2): FIFO0 holds 0x0FF, 0x0EE, others empty → pop=4'b0001 for two cycles. push_out=1 for the next two cycles with data_out 0x0FF then 0x0EE, grant_id=0.
3. Fairness: all four FIFOs hold 4 words each (0x0A0.., 0x1B0.., 0x2C0.., 0x3D0..) → grant_id sequence 0,0,1,1,2,2,3,3,0,0,1,1,…. Total 16 pushes, no idle cycles.
4. Backpressure: mid-burst on source 1, hold out_almostfull=1 for 3 cycles → pop=0 and push_out=0 one cycle later. On release, the second word of source 1 is granted before source 2.
5. Early termination: FIFO1={0x1DD}, FIFO2={0x2AA}, rr_ptr=1 → pushes 0x1DD then 0x2AA on consecutive cycles, grant_id 1 then 2.
6. Wrap: only FIFO3 and FIFO0 non-empty with BURST=1 → grants alternate 3,0,3,0, confirming the 3→0 pointer wrap.

Source files
------------

// File: rtl/arbiter4x1_rr.sv
// ---------------------------------------------------------------------------
// arbiter4x1_rr
//   Round-robin burst arbiter draining four show-ahead FIFOs into one shared
//   downstream FIFO. A source keeps the link for up to BURST consecutive
//   words, then priority rotates to the next source. Downstream almost-full
//   freezes all arbitration state for that cycle.
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-high reset
//   fifo_empty[3:0] per-source empty flags
//   fifo_data0..3   head word of each source FIFO
//   out_almostfull  downstream cannot take a word next cycle
//   pop[3:0]        combinational one-hot (or zero) pop strobe to the sources
//   push_out        registered push strobe to the downstream FIFO
//   data_out        registered word being pushed
//   grant_id        registered index of the source that supplied data_out
// ---------------------------------------------------------------------------
module arbiter4x1_rr #(
    parameter int DATA_SIZE = 10,
    parameter int BURST     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data0,
    input  logic [DATA_SIZE-1:0] fifo_data1,
    input  logic [DATA_SIZE-1:0] fifo_data2,
    input  logic [DATA_SIZE-1:0] fifo_data3,
    input  logic                 out_almostfull,
    output logic [3:0]           pop,
    output logic                 push_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [1:0]           grant_id
);

    typedef enum logic {ST_ARB, ST_BURST} state_t;

    state_t     state;
    logic [1:0] cur;
    logic [1:0] rr_ptr;
    logic [3:0] cnt;

    logic [DATA_SIZE-1:0] head [4];

    logic       burst_cont;
    logic [1:0] scan_base;
    logic [1:0] scan_idx;
    logic [1:0] scan_sel;
    logic       scan_hit;
    logic [1:0] sel;
    logic       grant;
    logic [3:0] cnt_inc;
    logic       burst_last;

    assign head[0] = fifo_data0;
    assign head[1] = fifo_data1;
    assign head[2] = fifo_data2;
    assign head[3] = fifo_data3;

    assign cnt_inc    = cnt + 4'd1;
    assign burst_last = (cnt_inc == 4'(BURST));

    // Pop decision (stage 0): combinational from flags and current state
    always_comb begin
        burst_cont = (state == ST_BURST) && !fifo_empty[cur];
        // A burst whose source ran dry rescans from the next source in the
        // same cycle, so no idle slot appears on the link.
        scan_base  = (state == ST_BURST) ? cur + 2'd1 : rr_ptr;
        scan_hit   = 1'b0;
        scan_sel   = scan_base;
        scan_idx   = 2'd0;
        // Walk from the farthest candidate back to the base so the closest
        // non-empty source in rotation order is the one left selected.
        for (int k = 3; k >= 0; k--) begin
            scan_idx = scan_base + 2'(k);
            if (!fifo_empty[scan_idx]) begin
                scan_hit = 1'b1;
                scan_sel = scan_idx;
            end
        end
        sel   = burst_cont ? cur : scan_sel;
        grant = !reset && !out_almostfull && (burst_cont || scan_hit);
        pop   = grant ? (4'b0001 << sel) : 4'b0000;
    end

    // Output register and arbitration state (stage 1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ARB;
            cur      <= 2'd0;
            rr_ptr   <= 2'd0;
            cnt      <= 4'd0;
            push_out <= 1'b0;
            data_out <= '0;
            grant_id <= 2'd0;
        end else begin
            push_out <= grant;
            if (grant) begin
                data_out <= head[sel];
                grant_id <= sel;
            end

            if (grant && burst_cont) begin
                cnt <= cnt_inc;
                if (burst_last) begin
                    rr_ptr <= cur + 2'd1;
                    state  <= ST_ARB;
                end
            end else if (grant) begin
                cur <= sel;
                cnt <= 4'd1;
                if (BURST == 1) begin
                    rr_ptr <= sel + 2'd1;
                    state  <= ST_ARB;
                end else begin
                    state  <= ST_BURST;
                end
            end else if (!out_almostfull && (state == ST_BURST)) begin
                // Current source drained and nobody else is waiting.
                state <= ST_ARB;
            end
        end
    end

endmodule

// File: tb/tb_arbiter4x1_rr.sv
// ---------------------------------------------------------------------------
// tb_arbiter4x1_rr
//   Two arbiter instances (BURST=2 and BURST=1) fed by simple FIFO models.
//   Expected (grant_id, data) pairs are queued as stimulus is loaded and
//   consumed whenever push_out is seen.
// ---------------------------------------------------------------------------
module tb_arbiter4x1_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic        af;
    logic        flush;

    logic [7:0]  fe;
    logic [9:0]  fd [8];
    logic [3:0]  pop0, pop1;
    logic [7:0]  popv;
    logic        push0, push1;
    logic [9:0]  dout0, dout1;
    logic [1:0]  gid0, gid1;

    logic [9:0]  mem [8][64];
    int          rd [8];
    int          wr [8];

    logic [11:0] exp_q [$];
    logic [11:0] exp1_q [$];

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    arbiter4x1_rr #(.DATA_SIZE(10), .BURST(2)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fe[3:0]),
        .fifo_data0(fd[0]), .fifo_data1(fd[1]), .fifo_data2(fd[2]), .fifo_data3(fd[3]),
        .out_almostfull(af), .pop(pop0), .push_out(push0),
        .data_out(dout0), .grant_id(gid0)
    );

    arbiter4x1_rr #(.DATA_SIZE(10), .BURST(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(fe[7:4]),
        .fifo_data0(fd[4]), .fifo_data1(fd[5]), .fifo_data2(fd[6]), .fifo_data3(fd[7]),
        .out_almostfull(af), .pop(pop1), .push_out(push1),
        .data_out(dout1), .grant_id(gid1)
    );

    assign popv = {pop1, pop0};

    for (genvar g = 0; g < 8; g++) begin : g_fifo
        assign fe[g] = (rd[g] == wr[g]);
        assign fd[g] = mem[g][rd[g]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (flush)        rd[i] <= wr[i];
            else if (popv[i]) rd[i] <= rd[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int f, input logic [9:0] w);
        mem[f][wr[f]] = w;
        wr[f] = wr[f] + 1;
    endtask

    task automatic expect0(input logic [1:0] id, input logic [9:0] d);
        exp_q.push_back({id, d});
    endtask

    task automatic expect1(input logic [1:0] id, input logic [9:0] d);
        exp1_q.push_back({id, d});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size() + exp1_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [11:0] e;
        if (push0) begin
            if (exp_q.size() == 0) chk("dut0_spurious_push", 32'(exp_q.size()), 1);
            else begin
                e = exp_q.pop_front();
                chk("dut0_grant_id", 32'(gid0), 32'(e[11:10]));
                chk("dut0_data_out", 32'(dout0), 32'(e[9:0]));
            end
        end
        if (push1) begin
            if (exp1_q.size() == 0) chk("dut1_spurious_push", 32'(exp1_q.size()), 1);
            else begin
                e = exp1_q.pop_front();
                chk("dut1_grant_id", 32'(gid1), 32'(e[11:10]));
                chk("dut1_data_out", 32'(dout1), 32'(e[9:0]));
            end
        end
        if (pop0 != 4'd0) begin
            chk("pop0_onehot", 32'($onehot(pop0)), 1);
            chk("pop0_on_empty", 32'(pop0 & fe[3:0]), 0);
        end
        if (pop1 != 4'd0) begin
            chk("pop1_onehot", 32'($onehot(pop1)), 1);
            chk("pop1_on_empty", 32'(pop1 & fe[7:4]), 0);
        end
    end

    initial begin
        logic [9:0] base [4];
        logic [3:0] seq6 [4];
        base[0] = 10'h0A0; base[1] = 10'h1B0; base[2] = 10'h2C0; base[3] = 10'h3D0;
        seq6[0] = 4'b1000; seq6[1] = 4'b0001; seq6[2] = 4'b1000; seq6[3] = 4'b0001;

        reset = 1'b1;
        af    = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_pop", 32'(pop0), 0);
        chk("rst_push", 32'(push0), 0);
        chk("rst_data", 32'(dout0), 0);
        chk("rst_gid", 32'(gid0), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single source, two-word burst
        @(posedge clk); #1;
        load(0, 10'h0FF); load(0, 10'h0EE);
        expect0(2'd0, 10'h0FF); expect0(2'd0, 10'h0EE);
        @(negedge clk); chk("single_pop_a", 32'(pop0), 32'h1);
        @(negedge clk); chk("single_pop_b", 32'(pop0), 32'h1);
        @(negedge clk); chk("single_pop_idle", 32'(pop0), 0);
        drain();

        // Reset in the middle of a burst on source 1
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) load(1, 10'h110 + 10'(k));
        load(2, 10'h2F0); load(2, 10'h2F1);
        @(posedge clk);
        #3 reset = 1'b1; flush = 1'b1;
        #1;
        chk("midrst_pop", 32'(pop0), 0);
        chk("midrst_push", 32'(push0), 0);
        chk("midrst_data", 32'(dout0), 0);
        chk("midrst_gid", 32'(gid0), 0);
        #14 reset = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        load(2, 10'h2E0); load(2, 10'h2E1);
        load(0, 10'h0E0); load(0, 10'h0E1);
        expect0(2'd0, 10'h0E0); expect0(2'd0, 10'h0E1);
        expect0(2'd2, 10'h2E0); expect0(2'd2, 10'h2E1);
        @(negedge clk); chk("postrst_first_src0", 32'(pop0), 32'h1);
        drain();

        // Fairness with all four sources loaded, starting from a clean pointer
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) load(s, base[s] + 10'(k));
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < 2; k++) expect0(2'(s), base[s] + 10'(r * 2 + k));
        @(negedge clk); chk("fair_first_pop", 32'(pop0), 32'h1);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            chk("fair_no_idle", 32'(push0), 1);
        end
        drain();

        // Backpressure in the middle of a source-1 burst
        load(1, 10'h1A0); load(1, 10'h1A1);
        load(2, 10'h2A0); load(2, 10'h2A1);
        expect0(2'd1, 10'h1A0); expect0(2'd1, 10'h1A1);
        expect0(2'd2, 10'h2A0); expect0(2'd2, 10'h2A1);
        @(negedge clk); chk("bp_first_pop", 32'(pop0), 32'h2);
        @(posedge clk); #1 af = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_pop_held", 32'(pop0), 0);
            if (k != 0) chk("bp_push_held", 32'(push0), 0);
            @(posedge clk);
        end
        #1 af = 1'b0;
        @(negedge clk);
        chk("bp_resume_src1", 32'(pop0), 32'h2);
        chk("bp_resume_push", 32'(push0), 0);
        drain();

        // Early burst termination hands over without an idle cycle
        load(0, 10'h0C0); load(0, 10'h0C1);
        expect0(2'd0, 10'h0C0); expect0(2'd0, 10'h0C1);
        drain();
        load(1, 10'h1DD); load(2, 10'h2AA);
        expect0(2'd1, 10'h1DD); expect0(2'd2, 10'h2AA);
        @(negedge clk); chk("early_pop_src1", 32'(pop0), 32'h2);
        @(negedge clk); chk("early_pop_src2", 32'(pop0), 32'h4);
        chk("early_push_a", 32'(push0), 1);
        @(negedge clk); chk("early_push_b", 32'(push0), 1);
        drain();

        // BURST=1 instance: pointer wrap between sources 3 and 0
        load(6, 10'h2B0);
        expect1(2'd2, 10'h2B0);
        drain();
        load(7, 10'h3B0); load(7, 10'h3B1);
        load(4, 10'h0B0); load(4, 10'h0B1);
        expect1(2'd3, 10'h3B0); expect1(2'd0, 10'h0B0);
        expect1(2'd3, 10'h3B1); expect1(2'd0, 10'h0B1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("wrap_pop", 32'(pop1), 32'(seq6[n]));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
